ecc_corrector: RTL
==================

Name: ecc_corrector

Overview:
- Downstream of the decode path: takes each segment's Reed-Solomon decode result (status, up to 2 error locations and magnitudes) and repairs the 512-byte page buffer in SRAM.
- Repair is a read-modify-write: the bad byte is read, XORed with the error magnitude, and written back.
- Keeps page-level correction statistics for firmware.
- Sits beside the syndrome/RS decoder and shares the SRAM port with it through an integration mux gated by busy.

Parameters:
- D, 1, register update delay for simulation (#D on all nonblocking assigns).
- SEG_LEN, 176, codeword bytes per segment (172 info + 4 parity).
- FLAG_POS, 160, segment-2 codeword position of the first of 4 flag bytes (not stored in SRAM).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- pageStart  in  1  1-cycle pulse: clear page statistics, return to IDLE.
- rsDone  in  1  1-cycle pulse: rsResults valid this cycle.
- rsResults  in  34  {code[1:0], loc1[7:0], mag1[7:0], loc2[7:0], mag2[7:0]}; code 00=clean, 01=one error, 10=two errors, 11=uncorrectable.
- segIdx  in  2  segment (0..2) the result belongs to; sampled with rsDone.
- memAdrs  out  9  SRAM byte address.
- memCEn  out  1  SRAM chip enable, active-low.
- memWEn  out  1  SRAM write enable, active-low.
- memDi  out  8  SRAM write data.
- memDo  in  8  SRAM read data, valid 1 cycle after a read is issued.
- busy  out  1  high while a result is being applied (owns SRAM port).
- segDone  out  1  1-cycle pulse when a result has been fully applied.
- status  out  8  {uncorr, overrun, errCnt[5:0]}.

Behaviour:
- Reset values: memAdrs=0, memCEn=1, memWEn=1, memDi=0, busy=0, segDone=0, status=0, FSM=IDLE.
- Location loc = codeword byte position; 0 = first byte of the segment on the flash stream; 172..175 = parity.
- Address map:
  - seg0: adr = loc.
  - seg1: adr = 172 + loc.
  - seg2, loc < 160: adr = 344 + loc.
  - seg2, 160..163: flag bytes, no SRAM location.
  - seg2, 164..171: adr = 340 + loc.
  - Any segment, loc 172..175: parity, skipped (no write, still counted).
  - seg2, loc 160..163: skipped the same way (no write, still counted).
- Validity: loc >= 176, mag == 0, or (code 10 and loc1 == loc2) force uncorrectable handling.
- Uncorrectable handling: sets uncorr sticky, performs no SRAM access, and still pulses segDone.
- FSM states: IDLE, RD1, WR1, RD2, WR2, FIN.
- IDLE:
  - On rsDone, latch rsResults and segIdx.
  - code 00 -> FIN.
  - code 11 or invalid -> set uncorr, go to FIN.
  - code 01/10 -> RD1 (or RD2 if error 1 is skipped and code 10).
- RDn:
  - Drive memAdrs=adrN, memCEn=0, memWEn=1.
  - Next state WRn.
- WRn:
  - memCEn=0, memWEn=0, memAdrs held, memDi = memDo ^ magN.
  - errCnt += 1, saturating at 63.
  - Next state RD2 if code 10 and n=1 (skip to FIN if error 2 is skipped); otherwise FIN.
- FIN: segDone=1 for one cycle, then IDLE.
- Skipped locations: increment errCnt and go directly to the next step with no SRAM access.
- busy is high in every state except IDLE.
- Latency from rsDone to segDone:
  - clean: 2 cycles.
  - 1 error: 4 cycles.
  - 2 errors: 6 cycles.
- Outside RD/WR: memCEn=1 and memWEn=1.
- rsDone while busy: result dropped, overrun sticky set, current operation unaffected.
- pageStart:
  - Clears errCnt, uncorr and overrun.
  - Aborts any operation in flight with no write issued in the next cycle; segDone is not pulsed.
  - pageStart and rsDone in the same cycle: pageStart wins, the result is dropped, and overrun is not set.
- Reset mid-operation: immediate return to reset values; an in-flight write is abandoned.

Decomposition:
- Shared package (ecc_pkg):
  - RS result field offsets and code constants.
  - SEG_LEN, segment SRAM base addresses 0/172/344, FLAG_POS, parity start 172.
- One sub-module, ecc_loc2adr: combinational mapping of {segIdx, loc} to {adr[8:0], skip, invalid}, instantiated twice (one per error).

Test Plan:
- seg0, code 01, loc1=5, mag1=0x3C, memDo returns 0xA5 -> read adr 5, write 0x99 to adr 5; segDone at +4 cycles; status=0x01.
- seg1, code 10, loc 0/mag 0x01 and loc 171/mag 0x80 -> writes to adr 172 and 343; status errCnt=2; segDone at +6 cycles.
- seg2, code 10, loc1=161 (flag), loc2=165/mag 0x0F -> no access for error 1; single RMW at adr 505; errCnt += 2.
- code 11, then code 10 with loc1 == loc2 = 9 -> no SRAM access, uncorr=1, segDone pulsed each time.
- rsDone pulsed again 1 cycle after an accepted 2-error result -> overrun=1, only the first result's two writes occur.
- pageStart during WR1 wait (asserted in RD1) -> no write, FSM IDLE, status=0x00; reset asserted mid-RD2 -> all outputs at reset values next edge.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared types and constants for the RS error corrector.
package ecc_pkg;

   // Segment geometry in codeword bytes
   localparam logic [8:0] SegLen       = 9'd176;
   localparam logic [8:0] ParityPos    = 9'd172;
   localparam logic [8:0] FlagPos      = 9'd160;
   localparam logic [8:0] FlagEnd      = 9'd164;

   // SRAM base address of each segment; segment 2 tail sits after the dropped flag bytes
   localparam logic [8:0] Seg0Base     = 9'd0;
   localparam logic [8:0] Seg1Base     = 9'd172;
   localparam logic [8:0] Seg2Base     = 9'd344;
   localparam logic [8:0] Seg2TailBase = 9'd340;

   localparam logic [5:0] CntMax       = 6'd63;

   typedef enum logic [1:0] {
      CodeClean  = 2'b00,
      CodeOne    = 2'b01,
      CodeTwo    = 2'b10,
      CodeUncorr = 2'b11
   } code_e;

   // Bit layout of the 34-bit decoder result, MSB first
   typedef struct packed {
      code_e      code;
      logic [7:0] loc1;
      logic [7:0] mag1;
      logic [7:0] loc2;
      logic [7:0] mag2;
   } rs_result_t;

   typedef enum logic [2:0] {
      StIdle,
      StRd1,
      StWr1,
      StRd2,
      StWr2,
      StFin
   } state_e;

endpackage

// File: rtl/ecc_loc2adr.sv
// Maps a segment index and codeword location to a page-buffer address.
module ecc_loc2adr
   import ecc_pkg::*;
(
   input  logic [1:0] seg_i,
   input  logic [7:0] loc_i,
   output logic [8:0] adr_o,
   output logic       skip_o,
   output logic       invalid_o
);

   logic [8:0] loc9;

   assign loc9 = {1'b0, loc_i};

   // Parity and flag bytes have no SRAM home; out-of-range locations are invalid
   always_comb begin
      adr_o     = '0;
      skip_o    = 1'b0;
      invalid_o = 1'b0;
      if (loc9 >= SegLen) begin
         invalid_o = 1'b1;
      end else if (loc9 >= ParityPos) begin
         skip_o = 1'b1;
      end else begin
         unique case (seg_i)
            2'd0: adr_o = Seg0Base + loc9;
            2'd1: adr_o = Seg1Base + loc9;
            2'd2: begin
               if (loc9 < FlagPos) begin
                  adr_o = Seg2Base + loc9;
               end else if (loc9 < FlagEnd) begin
                  skip_o = 1'b1;
               end else begin
                  adr_o = Seg2TailBase + loc9;
               end
            end
            default: invalid_o = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/ecc_corrector.sv
// Applies RS decode results to the page buffer by read-modify-write and keeps page stats.
module ecc_corrector
   import ecc_pkg::*;
(
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        page_start_i,
   input  logic        rs_done_i,
   input  logic [33:0] rs_results_i,
   input  logic [1:0]  seg_idx_i,
   output logic [8:0]  mem_adrs_o,
   output logic        mem_cen_o,
   output logic        mem_wen_o,
   output logic [7:0]  mem_di_o,
   input  logic [7:0]  mem_do_i,
   output logic        busy_o,
   output logic        seg_done_o,
   output logic [7:0]  status_o
);

   state_e     state_q, state_d;
   rs_result_t res_q, res_d, cur_res;
   logic [1:0] seg_q, seg_d, cur_seg;
   logic       uncorr_q, uncorr_d;
   logic       overrun_q, overrun_d;
   logic       seg_done_q, seg_done_d;
   logic [5:0] err_cnt_q, err_cnt_d;
   logic [1:0] cnt_inc;
   logic [6:0] cnt_sum;
   logic [8:0] adr1, adr2;
   logic       skip1, skip2, inv1, inv2;
   logic       bad;

   // Decode the live result while idle so the first step is chosen on the rsDone cycle
   assign cur_res = (state_q == StIdle) ? rs_result_t'(rs_results_i) : res_q;
   assign cur_seg = (state_q == StIdle) ? seg_idx_i : seg_q;

   ecc_loc2adr u_map1 (
      .seg_i     (cur_seg),
      .loc_i     (cur_res.loc1),
      .adr_o     (adr1),
      .skip_o    (skip1),
      .invalid_o (inv1)
   );

   ecc_loc2adr u_map2 (
      .seg_i     (cur_seg),
      .loc_i     (cur_res.loc2),
      .adr_o     (adr2),
      .skip_o    (skip2),
      .invalid_o (inv2)
   );

   // A result is unusable if any error it claims is out of range, zero, or duplicated
   always_comb begin
      bad = 1'b0;
      if (cur_res.code == CodeOne) begin
         bad = inv1 || (cur_res.mag1 == 8'd0);
      end else if (cur_res.code == CodeTwo) begin
         bad = inv1 || inv2 || (cur_res.mag1 == 8'd0) || (cur_res.mag2 == 8'd0) ||
               (cur_res.loc1 == cur_res.loc2);
      end
   end

   // Sequencing, SRAM port drive and sticky status updates
   always_comb begin
      state_d    = state_q;
      res_d      = res_q;
      seg_d      = seg_q;
      uncorr_d   = uncorr_q;
      overrun_d  = overrun_q;
      seg_done_d = 1'b0;
      cnt_inc    = 2'd0;
      mem_adrs_o = '0;
      mem_cen_o  = 1'b1;
      mem_wen_o  = 1'b1;
      mem_di_o   = '0;

      unique case (state_q)
         StIdle: begin
            if (rs_done_i) begin
               res_d = cur_res;
               seg_d = cur_seg;
               unique case (cur_res.code)
                  CodeClean: state_d = StFin;
                  CodeUncorr: begin
                     uncorr_d = 1'b1;
                     state_d  = StFin;
                  end
                  default: begin
                     if (bad) begin
                        uncorr_d = 1'b1;
                        state_d  = StFin;
                     end else if (!skip1) begin
                        state_d = StRd1;
                     end else if (cur_res.code == CodeTwo) begin
                        // Skipped error still counts; both may be skipped at once
                        cnt_inc = skip2 ? 2'd2 : 2'd1;
                        state_d = skip2 ? StFin : StRd2;
                     end else begin
                        cnt_inc = 2'd1;
                        state_d = StFin;
                     end
                  end
               endcase
            end
         end
         StRd1: begin
            mem_adrs_o = adr1;
            mem_cen_o  = 1'b0;
            state_d    = StWr1;
         end
         StWr1: begin
            mem_adrs_o = adr1;
            mem_cen_o  = 1'b0;
            mem_wen_o  = 1'b0;
            mem_di_o   = mem_do_i ^ res_q.mag1;
            if (res_q.code == CodeTwo) begin
               cnt_inc = skip2 ? 2'd2 : 2'd1;
               state_d = skip2 ? StFin : StRd2;
            end else begin
               cnt_inc = 2'd1;
               state_d = StFin;
            end
         end
         StRd2: begin
            mem_adrs_o = adr2;
            mem_cen_o  = 1'b0;
            state_d    = StWr2;
         end
         StWr2: begin
            mem_adrs_o = adr2;
            mem_cen_o  = 1'b0;
            mem_wen_o  = 1'b0;
            mem_di_o   = mem_do_i ^ res_q.mag2;
            cnt_inc    = 2'd1;
            state_d    = StFin;
         end
         StFin: begin
            seg_done_d = 1'b1;
            state_d    = StIdle;
         end
         default: state_d = StIdle;
      endcase

      if ((state_q != StIdle) && rs_done_i) begin
         overrun_d = 1'b1;
      end

      // Page restart overrides everything, including a same-cycle rsDone
      if (page_start_i) begin
         state_d    = StIdle;
         uncorr_d   = 1'b0;
         overrun_d  = 1'b0;
         seg_done_d = 1'b0;
      end
   end

   // Saturating error counter, cleared at page start
   always_comb begin
      cnt_sum   = {1'b0, err_cnt_q} + {5'd0, cnt_inc};
      err_cnt_d = (cnt_sum > {1'b0, CntMax}) ? CntMax : cnt_sum[5:0];
      if (page_start_i) begin
         err_cnt_d = '0;
      end
   end

   // State and status registers
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= StIdle;
         res_q      <= '0;
         seg_q      <= '0;
         uncorr_q   <= 1'b0;
         overrun_q  <= 1'b0;
         seg_done_q <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         res_q      <= res_d;
         seg_q      <= seg_d;
         uncorr_q   <= uncorr_d;
         overrun_q  <= overrun_d;
         seg_done_q <= seg_done_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign busy_o     = (state_q != StIdle);
   assign seg_done_o = seg_done_q;
   assign status_o   = {uncorr_q, overrun_q, err_cnt_q};

endmodule
